// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared constants, index-width helper and hold-entry type for the crossbar
package switch_pkg;

    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int MAX_PORT_IDX_W = 4;

    // Width of a port index; never below one bit so two-port builds still get a select line.
    function automatic int port_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [DEF_DATA_W-1:0]     data;
        logic [DEF_ADDR_W-1:0]     dest;
        logic [MAX_PORT_IDX_W-1:0] src;
    } hold_entry_t;

endpackage

// File: rtl/sw_out_fifo.sv
// rtl/sw_out_fifo.sv - one show-ahead output FIFO holding payload and source index
// Push is refused when full at the start of the cycle; a same-cycle pop never makes room.
module sw_out_fifo
    import switch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SRC_W  = 2,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [SRC_W-1:0]  push_src_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic              full_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic [SRC_W-1:0]  head_src_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [SRC_W-1:0]  src_mem_q  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign valid_o = (count_q != '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & valid_o;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem_q[wr_ptr_q] <= push_data_i;
            src_mem_q[wr_ptr_q]  <= push_src_i;
        end
    end

    // Stale storage is masked so an empty FIFO always presents zeros.
    assign head_data_o = valid_o ? data_mem_q[rd_ptr_q] : '0;
    assign head_src_o  = valid_o ? src_mem_q[rd_ptr_q]  : '0;

endmodule

// File: rtl/xbar_switch.sv
// rtl/xbar_switch.sv - NxN crossbar: per-input hold register, per-output round-robin grant into a FIFO
// Optional per-output write counters on pkt_cnt when SWITCH_STATS_EN is defined.
module xbar_switch
    import switch_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS*DATA_W-1:0] data_in,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr_in,
    input  logic [NUM_PORTS-1:0]        valid_in,
    output logic [NUM_PORTS-1:0]        rcv_rdy,
    output logic [NUM_PORTS*DATA_W-1:0] data_out,
    output logic [NUM_PORTS*ADDR_W-1:0] addr_out,
    output logic [NUM_PORTS-1:0]        valid_out,
    input  logic [NUM_PORTS-1:0]        data_rd
`ifdef SWITCH_STATS_EN
   ,output logic [NUM_PORTS*16-1:0]     pkt_cnt
`endif
);

    localparam int PW = port_idx_w(NUM_PORTS);

    logic [NUM_PORTS-1:0] hold_vld_q, hold_vld_d;
    logic [DATA_W-1:0]    hold_data_q [NUM_PORTS];
    logic [PW-1:0]        hold_dest_q [NUM_PORTS];
    logic [PW-1:0]        rr_q        [NUM_PORTS];
    logic [PW-1:0]        rr_d        [NUM_PORTS];
    logic [PW-1:0]        grant_src   [NUM_PORTS];
    logic [NUM_PORTS-1:0] accept, free, grant, fifo_full;
    int                   k;

    assign rcv_rdy    = ~hold_vld_q & {NUM_PORTS{~reset}};
    assign accept     = valid_in & rcv_rdy;
    assign hold_vld_d = (hold_vld_q | accept) & ~free;

    always_comb begin
        free  = '0;
        grant = '0;
        k     = 0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            grant_src[j] = '0;
            rr_d[j]      = rr_q[j];
            for (int i = 0; i < NUM_PORTS; i++) begin
                k = (int'(rr_q[j]) + i) % NUM_PORTS;
                if (!grant[j] && !fifo_full[j] && hold_vld_q[k] && int'(hold_dest_q[k]) == j) begin
                    grant[j]     = 1'b1;
                    grant_src[j] = PW'(k);
                end
            end
            if (grant[j]) begin
                free[grant_src[j]] = 1'b1;
                rr_d[j] = (int'(grant_src[j]) == NUM_PORTS-1) ? '0 : grant_src[j] + 1'b1;
            end
        end
        // Destinations past the last port (non-power-of-two builds) are discarded.
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (hold_vld_q[p] && int'(hold_dest_q[p]) >= NUM_PORTS) begin
                free[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_vld_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                hold_data_q[p] <= '0;
                hold_dest_q[p] <= '0;
                rr_q[p]        <= '0;
            end
        end else begin
            hold_vld_q <= hold_vld_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (accept[p]) begin
                    hold_data_q[p] <= data_in[p*DATA_W +: DATA_W];
                    hold_dest_q[p] <= addr_in[p*ADDR_W +: PW];
                end
                rr_q[p] <= rr_d[p];
            end
        end
    end

    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
        logic [PW-1:0] head_src;

        sw_out_fifo #(
            .DATA_W (DATA_W),
            .SRC_W  (PW),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .push_i      (grant[j]),
            .push_data_i (hold_data_q[grant_src[j]]),
            .push_src_i  (grant_src[j]),
            .pop_i       (data_rd[j]),
            .valid_o     (valid_out[j]),
            .full_o      (fifo_full[j]),
            .head_data_o (data_out[j*DATA_W +: DATA_W]),
            .head_src_o  (head_src)
        );

        assign addr_out[j*ADDR_W +: ADDR_W] = ADDR_W'(head_src);
    end

`ifdef SWITCH_STATS_EN
    logic [15:0] cnt_q [NUM_PORTS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant[p] && cnt_q[p] != 16'hFFFF) cnt_q[p] <= cnt_q[p] + 1'b1;
            end
        end
    end

    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_cnt
        assign pkt_cnt[j*16 +: 16] = cnt_q[j];
    end
`endif

endmodule

// File: tb/tb_xbar_switch.sv
// tb/tb_xbar_switch.sv - randomized and directed bench for xbar_switch against a queue-based model
module tb_xbar_switch;
    import switch_pkg::*;

    localparam int NP = 4, DW = 8, AW = 8, DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*DW-1:0]  data_in, data_out;
    logic [NP*AW-1:0]  addr_in, addr_out;
    logic [NP-1:0]     valid_in, rcv_rdy, valid_out, data_rd;
`ifdef SWITCH_STATS_EN
    logic [NP*16-1:0]  pkt_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    xbar_switch #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .addr_in(addr_in), .valid_in(valid_in),
        .rcv_rdy(rcv_rdy), .data_out(data_out), .addr_out(addr_out), .valid_out(valid_out),
        .data_rd(data_rd)
`ifdef SWITCH_STATS_EN
       ,.pkt_cnt(pkt_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending packet per input, a queue per output, a next-search index per output.
    hold_entry_t mh  [NP];
    bit          mh_v[NP];
    hold_entry_t mq  [NP][$];
    int          mrr [NP];
    int          mcnt[NP];
    bit          acc [NP];
    bit          g   [NP];
    int          gk  [NP];
    int          occ [NP];
    int          mk;
    hold_entry_t me;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NP; i++) begin
                mh_v[i] = 1'b0;
                mq[i].delete();
                mrr[i]  = 0;
                mcnt[i] = 0;
            end
        end else begin
            for (int p = 0; p < NP; p++) acc[p] = valid_in[p] && !mh_v[p];
            for (int j = 0; j < NP; j++) begin
                occ[j] = mq[j].size();
                g[j]   = 1'b0;
                gk[j]  = 0;
                if (occ[j] < DEPTH) begin
                    for (int i = 0; i < NP; i++) begin
                        mk = (mrr[j] + i) % NP;
                        if (!g[j] && mh_v[mk] && (mh[mk].dest % NP) == j) begin
                            g[j]  = 1'b1;
                            gk[j] = mk;
                        end
                    end
                end
            end
            for (int j = 0; j < NP; j++) begin
                if (data_rd[j] && occ[j] > 0) void'(mq[j].pop_front());
            end
            for (int j = 0; j < NP; j++) begin
                if (g[j]) begin
                    me     = mh[gk[j]];
                    me.src = 4'(gk[j]);
                    mq[j].push_back(me);
                    mh_v[gk[j]] = 1'b0;
                    mrr[j] = (gk[j] + 1) % NP;
                    if (mcnt[j] < 65535) mcnt[j]++;
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) begin
                    mh_v[p]     = 1'b1;
                    mh[p].data  = data_in[p*DW +: DW];
                    mh[p].dest  = addr_in[p*AW +: AW];
                    mh[p].src   = 4'(p);
                end
            end
        end
    end

    logic [NP-1:0]    exp_rdy, exp_vout;
    logic [NP*DW-1:0] exp_dout;
    logic [NP*AW-1:0] exp_aout;
    logic [NP*16-1:0] exp_cnt;

    always @(negedge clk) begin
        exp_rdy  = '0;
        exp_vout = '0;
        exp_dout = '0;
        exp_aout = '0;
        exp_cnt  = '0;
        for (int j = 0; j < NP; j++) begin
            exp_rdy[j]         = !reset && !mh_v[j];
            exp_cnt[j*16 +: 16] = 16'(mcnt[j]);
            if (mq[j].size() > 0) begin
                exp_vout[j]          = 1'b1;
                exp_dout[j*DW +: DW] = mq[j][0].data;
                exp_aout[j*AW +: AW] = AW'(mq[j][0].src);
            end
        end
        chk("rcv_rdy", rcv_rdy, exp_rdy);
        chk("valid_out", valid_out, exp_vout);
        chk("data_out", data_out, exp_dout);
        chk("addr_out", addr_out, exp_aout);
`ifdef SWITCH_STATS_EN
        chk("pkt_cnt", pkt_cnt, exp_cnt);
`endif
    end

    task automatic set_in(input int p, input logic [7:0] d, input logic [7:0] a);
        data_in[p*DW +: DW] = d;
        addr_in[p*AW +: AW] = a;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        valid_in = '0;
        data_rd  = '0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int sent;
        reset = 1'b1; valid_in = '0; data_in = '0; addr_in = '0; data_rd = '0;
        repeat (3) @(negedge clk);
        chk("reset_rdy", rcv_rdy, 4'h0);
        chk("reset_vout", valid_out, 4'h0);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_rdy", rcv_rdy, 4'hF);

        // single packet in0 -> out2
        set_in(0, 8'hA5, 8'd2); valid_in = 4'b0001;
        @(negedge clk);
        chk("single_hold_rdy", rcv_rdy, 4'hE);
        chk("single_not_yet", valid_out, 4'h0);
        valid_in = '0;
        @(negedge clk);
        chk("single_vout", valid_out, 4'b0100);
        chk("single_data", data_out[23:16], 8'hA5);
        chk("single_src", addr_out[23:16], 8'h00);
        data_rd = 4'b0100;
        @(negedge clk);
        data_rd = '0;
        chk("single_popped", valid_out, 4'h0);

        // contention: all inputs to out1
        do_reset();
        for (int p = 0; p < NP; p++) set_in(p, 8'hC0 + 8'(p), 8'd1);
        valid_in = 4'hF;
        @(negedge clk);
        chk("cont_all_held", rcv_rdy, 4'h0);
        valid_in = '0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            chk("cont_free_order", rcv_rdy, 64'((1 << n) - 1));
        end
        for (int p = 0; p < NP; p++) begin
            chk("cont_src_order", addr_out[15:8], 64'(p));
            chk("cont_data_order", data_out[15:8], 64'(8'hC0 + 8'(p)));
            data_rd = 4'b0010;
            @(negedge clk);
        end
        data_rd = '0;
        chk("cont_drained", valid_out, 4'h0);

        // backpressure: in0 -> out3 with no pops
        do_reset();
        valid_in = 4'b0001;
        for (int i = 0; i < 14; i++) begin
            set_in(0, 8'h30 + 8'(i), 8'd3);
            @(negedge clk);
        end
        chk("bp_rdy_low", rcv_rdy, 4'hE);
        chk("bp_vout", valid_out, 4'b1000);
        chk("bp_head", data_out[31:24], 8'h30);
        valid_in = '0;
        data_rd  = 4'b1000;
        @(negedge clk);
        data_rd = '0;
        chk("bp_pop_only", rcv_rdy, 4'hE);
        chk("bp_new_head", data_out[31:24], 8'h32);
        @(negedge clk);
        chk("bp_push_next", rcv_rdy, 4'hF);
        chk("bp_still_valid", valid_out, 4'b1000);

        // reset mid-operation
        do_reset();
        for (int p = 0; p < 3; p++) set_in(p, 8'hD0 + 8'(p), 8'd1);
        valid_in = 4'b0111;
        @(negedge clk);
        valid_in = '0;
        repeat (4) @(negedge clk);
        chk("mid_three", valid_out, 4'b0010);
        #2 reset = 1'b1;
        #1;
        chk("mid_vout_clear", valid_out, 4'h0);
        chk("mid_rdy_low", rcv_rdy, 4'h0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rdy_back", rcv_rdy, 4'hF);
        @(negedge clk);
        set_in(3, 8'h5A, 8'hF0);
        valid_in = 4'b1000;
        @(negedge clk);
        valid_in = '0;
        @(negedge clk);
        chk("mid_route_vout", valid_out, 4'b0001);
        chk("mid_route_data", data_out[7:0], 8'h5A);
        chk("mid_route_src", addr_out[7:0], 8'h03);

`ifdef SWITCH_STATS_EN
        do_reset();
        sent = 0;
        data_rd = 4'b0001;
        for (int c = 0; c < 200 && sent < 20; c++) begin
            valid_in = 4'b0001;
            set_in(0, 8'($urandom), 8'd0);
            if (rcv_rdy[0]) sent++;
            @(negedge clk);
        end
        valid_in = '0;
        repeat (6) @(negedge clk);
        data_rd = '0;
        chk("stats_sent", 64'(sent), 64'd20);
        chk("stats_cnt", pkt_cnt, 64'd20);
`endif

        // randomized traffic with occasional resets
        do_reset();
        sent = 0;
        for (int c = 0; c < 3000; c++) begin
            valid_in = 4'($urandom);
            for (int p = 0; p < NP; p++) set_in(p, 8'($urandom), 8'($urandom));
            data_rd = 4'($urandom & $urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
            end
            @(negedge clk);
        end
        valid_in = '0;
        data_rd  = '0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xbar_switch.md
XBAR_SWITCH -- requirements
Module: xbar_switch

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, number of input and output ports (2..16).
REQ-002 The block SHALL have parameter DATA_W, default 8, per-port payload width.
REQ-003 The block SHALL have parameter ADDR_W, default 8, per-port address width (>= clog2(NUM_PORTS)).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, per-output FIFO entries (power of 2, >= 2).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port data_in, input, NUM_PORTS*DATA_W, payload; port k in slice k.
REQ-008 The block SHALL have port addr_in, input, NUM_PORTS*ADDR_W, destination; low clog2(NUM_PORTS) bits = output index.
REQ-009 The block SHALL have port valid_in, input, NUM_PORTS, per-input request.
REQ-010 The block SHALL have port rcv_rdy, output, NUM_PORTS, per-input ready.
REQ-011 The block SHALL have port data_out, output, NUM_PORTS*DATA_W, head-of-FIFO payload per output.
REQ-012 The block SHALL have port addr_out, output, NUM_PORTS*ADDR_W, source input index (zero-extended) of head entry.
REQ-013 The block SHALL have port valid_out, output, NUM_PORTS, per-output FIFO non-empty.
REQ-014 The block SHALL have port data_rd, input, NUM_PORTS, per-output pop strobe.

Function
REQ-015 Input k SHALL accept a packet at a rising edge where valid_in[k] and rcv_rdy[k] are both 1, capturing data/destination into a one-entry hold register.
REQ-016 rcv_rdy[k] SHALL be 1 iff hold register k is empty and reset is deasserted; a held packet with the destination FIFO full SHALL hold rcv_rdy[k] at 0 until granted.
REQ-017 Each output j SHALL grant at most one hold register per cycle, round-robin: search starts at rr_ptr[j], after grant rr_ptr[j] = (granted+1) mod NUM_PORTS; no grant leaves rr_ptr[j] unchanged.
REQ-018 A grant SHALL occur only if FIFO j is not full at the start of the cycle; a same-cycle pop SHALL NOT free space for a same-cycle push.
REQ-019 On grant the entry SHALL be written to FIFO j and hold register k freed at the same edge; rcv_rdy[k] returns to 1 the following cycle.
REQ-020 Minimum latency SHALL be 2 edges: accept at edge N, FIFO write at edge N+1, valid_out[j] = 1 in the cycle after N+1.
REQ-021 FIFOs SHALL be show-ahead: data_out/addr_out show the head while valid_out = 1 and are 0 when empty.
REQ-022 data_rd[j] with valid_out[j] = 1 SHALL pop one entry at the edge; data_rd[j] on an empty FIFO SHALL be ignored.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; simultaneous push and pop on a non-full, non-empty FIFO SHALL keep occupancy unchanged.
REQ-024 Destination bits above clog2(NUM_PORTS) SHALL be ignored; an index >= NUM_PORTS (non-power-of-2 NUM_PORTS) SHALL be dropped at grant time with hold register freed.
REQ-025 Packet order from one input to one output SHALL be preserved.

Reset
REQ-026 Asserting reset, including mid-transfer, SHALL immediately clear all hold registers, FIFOs, pointers, rr_ptr (to 0) and counters; in-flight packets are discarded.
REQ-027 During reset rcv_rdy, valid_out, data_out and addr_out SHALL be 0; rcv_rdy SHALL be all-ones in the first cycle after deassertion.

Configuration
REQ-028 With SWITCH_STATS_EN defined, output pkt_cnt (NUM_PORTS*16) SHALL count per-output FIFO writes, saturating at 16'hFFFF, cleared by reset; without it the port and counters SHALL be absent.

Structure
REQ-029 Package switch_pkg SHALL hold default parameter constants, the port-index width function and the hold-entry struct typedef (data, destination, source).
REQ-030 Sub-module sw_out_fifo SHALL implement one output FIFO, instantiated NUM_PORTS times via generate.

Verification
REQ-031 Single packet: in0 data 8'hA5 dest 2 -> out2 valid_out 2 cycles after accept, data 8'hA5, addr_out 0; pop empties it.
REQ-032 Contention: in0..in3 all to out1 same cycle, rr_ptr 0 -> FIFO order src 0,1,2,3, one write per cycle; rcv_rdy freed in that order.
REQ-033 Full/backpressure: 6 packets in0->out3, no pops, depth 4 -> 4 stored, 5th held, rcv_rdy[0] = 0; one pop -> 5th written next cycle.
REQ-034 Full plus pop same cycle: FIFO full, data_rd and pending grant same cycle -> only pop occurs, push next cycle.
REQ-035 Reset mid-operation: 3 entries in out1, reset asserted one cycle -> valid_out all 0 immediately; post-release rcv_rdy = 4'hF, new packet routes normally.
REQ-036 SWITCH_STATS_EN: 20 packets to out0 -> pkt_cnt[0] = 20, others 0; without macro elaboration succeeds with no pkt_cnt port.
